// File: rtl/tremolo_pkg.sv
// Shared definitions for the tremolo amplitude modulator.
// Contents:
//   state_t   - top-level sequencing states
//   constants - Q15 unity gain, LFO offset/clamp, depth limit, multiplier length
//   calc_gain - LFO + depth + enable -> unsigned Q15 gain in [0, 32768]
package tremolo_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAIN,
    S_MUL,
    S_DONE
  } state_t;

  localparam int                 Q15_ONE    = 32768;
  localparam logic signed [32:0] LFO_OFFSET = 33'sd1073741824;  // 2^30
  localparam logic signed [32:0] LFO_CLAMP  = 33'sd2147483648;  // 2^31
  localparam logic [3:0]         DEPTH_MAX  = 4'd8;
  localparam int                 MUL_CYCLES = 16;

  // The LFO swings +/-2^30, so shifting it up by 2^30 gives a unipolar
  // value whose top 16 bits (after >>16) are a Q15 gain 0..1.0. Depth then
  // blends between unity (depth 0) and the full LFO gain (depth 8).
  function automatic logic [15:0] calc_gain(
    input logic signed [31:0] lfo,
    input logic [3:0]         depth,
    input logic               en
  );
    logic signed [32:0] s;
    logic [16:0]        g;
    logic [3:0]         d;
    logic [16:0]        span;
    logic [20:0]        scaled;
    logic [16:0]        gain;
    s = 33'(lfo) + LFO_OFFSET;
    if (s < 0) begin
      s = '0;
    end else if (s > LFO_CLAMP) begin
      s = LFO_CLAMP;
    end
    g      = 17'(s >>> 16);
    d      = (depth > DEPTH_MAX) ? DEPTH_MAX : depth;
    span   = 17'(Q15_ONE) - g;
    scaled = 21'(d) * 21'(span);
    gain   = 17'(Q15_ONE) - 17'(scaled >> 3);
    if (!en) begin
      gain = 17'(Q15_ONE);
    end
    return 16'(gain);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Serial signed x unsigned multiplier, one multiplier bit per clock, LSB first.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   start          - load a/b and begin (ignored handling: restarts if busy)
//   a              - signed multiplicand
//   b              - unsigned multiplier
//   busy           - high while bits are being consumed
//   done           - high during the final step cycle; product is valid then
//   product        - final product, combinational, valid only while done=1
// The result is exposed during the last step (rather than one cycle later)
// so the caller can register it on the same edge the accumulator would.
module shift_add_mult
  import tremolo_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               start,
  input  logic signed [15:0] a,
  input  logic [15:0]        b,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] product
);

  logic signed [31:0] addend_reg;
  logic signed [31:0] acc_reg;
  logic [15:0]        mult_reg;
  logic [3:0]         bit_cnt_reg;
  logic               busy_reg;
  logic signed [31:0] sum;

  assign sum     = mult_reg[0] ? (acc_reg + addend_reg) : acc_reg;
  assign busy    = busy_reg;
  assign done    = busy_reg && (bit_cnt_reg == 4'(MUL_CYCLES - 1));
  assign product = sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addend_reg  <= '0;
      acc_reg     <= '0;
      mult_reg    <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else if (start) begin
      addend_reg  <= 32'(a);
      acc_reg     <= '0;
      mult_reg    <= b;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      acc_reg     <= sum;
      addend_reg  <= addend_reg <<< 1;
      mult_reg    <= mult_reg >> 1;
      bit_cnt_reg <= bit_cnt_reg + 4'd1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tremolo_modulator.sv
// Tremolo amplitude modulator: scales each audio sample by a Q15 gain
// derived from a triangle LFO and a depth control.
// Ports:
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_valid/o_ready - input handshake; o_ready is high only when idle
//   i_sample        - signed audio sample
//   i_lfo           - signed triangle LFO value, nominally +/-2^30
//   i_depth         - depth 0..8 (eighths), larger values act as 8
//   i_en            - 1 = modulate, 0 = pass the sample through unchanged
//   o_valid         - one-cycle pulse when o_sample updates
//   o_sample        - modulated sample, held until the next o_valid
// Transfer at edge N -> o_sample/o_valid update at edge N+17, ready again
// after edge N+18.
module tremolo_modulator
  import tremolo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LFO_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [LFO_W-1:0]  i_lfo,
  input  logic [3:0]        i_depth,
  input  logic              i_en,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_sample
);

  state_t             state_reg;
  state_t             state_next;
  logic signed [15:0] sample_reg;
  logic signed [31:0] lfo_reg;
  logic [3:0]         depth_reg;
  logic               en_reg;
  logic               valid_reg;
  logic [15:0]        out_reg;

  logic               transfer;
  logic [15:0]        gain;
  logic               mult_start;
  logic               mult_busy;
  logic               mult_done;
  logic signed [31:0] product;
  logic               finish;

  assign o_ready    = (state_reg == S_IDLE);
  assign transfer   = i_valid && o_ready;
  assign gain       = calc_gain(lfo_reg, depth_reg, en_reg);
  assign mult_start = (state_reg == S_GAIN);
  assign finish     = (state_reg == S_MUL) && mult_done;
  assign o_valid    = valid_reg;
  assign o_sample   = out_reg;

  shift_add_mult u_mult (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (mult_start),
    .a       (sample_reg),
    .b       (gain),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (product)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (transfer) state_next = S_GAIN;
      S_GAIN: state_next = S_MUL;
      // The busy check only matters if the multiplier were ever idle while
      // we wait on it; it keeps the FSM from getting stuck in S_MUL.
      S_MUL:  if (mult_done || !mult_busy) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= S_IDLE;
      sample_reg <= '0;
      lfo_reg    <= '0;
      depth_reg  <= '0;
      en_reg     <= 1'b0;
      valid_reg  <= 1'b0;
      out_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (transfer) begin
        sample_reg <= i_sample;
        lfo_reg    <= i_lfo;
        depth_reg  <= i_depth;
        en_reg     <= i_en;
      end
      valid_reg <= finish;
      // |gain| <= 1.0, so bits [30:15] of the product always fit in 16 bits.
      if (finish) begin
        out_reg <= 16'(product >>> 15);
      end
    end
  end

endmodule

// File: tb/tb_tremolo_modulator.sv
module tb_tremolo_modulator;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic signed [15:0] i_sample = '0;
  logic [31:0]        i_lfo = '0;
  logic [3:0]         i_depth = '0;
  logic               i_en = 1'b0;
  logic               o_valid;
  logic signed [15:0] o_sample;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  tremolo_modulator #(.DATA_W(16), .LFO_W(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sample (i_sample),
    .i_lfo    (i_lfo),
    .i_depth  (i_depth),
    .i_en     (i_en),
    .o_valid  (o_valid),
    .o_sample (o_sample)
  );

  // One full transaction: checks handshake, exact latency and the result.
  // Inputs are scrambled right after capture to prove they are latched.
  task automatic run_sample(input string name, input logic signed [15:0] x,
                            input logic [31:0] lfo, input logic [3:0] depth,
                            input logic en, input logic signed [15:0] expv);
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before got %0b exp 1", name, o_ready);
    end
    i_valid = 1'b1; i_sample = x; i_lfo = lfo; i_depth = depth; i_en = en;
    @(negedge i_clk);
    i_valid = 1'b0; i_sample = 16'sh5a5a; i_lfo = 32'h1234_5678;
    i_depth = 4'd3; i_en = ~en;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) @(negedge i_clk);
      checks++;
      if (o_ready !== (k == 18)) begin
        errors++;
        $display("FAIL %s ready_k%0d got %0b exp %0b", name, k, o_ready, (k == 18));
      end
      checks++;
      if (o_valid !== (k == 17)) begin
        errors++;
        $display("FAIL %s valid_k%0d got %0b exp %0b", name, k, o_valid, (k == 17));
      end
      if (k >= 17) begin
        checks++;
        if (o_sample !== expv) begin
          errors++;
          $display("FAIL %s sample_k%0d got %0d exp %0d", name, k, o_sample, expv);
        end
      end
    end
    $display("txn %s x=%0d lfo=%h depth=%0d en=%0b out=%0d exp=%0d",
             name, x, lfo, depth, en, o_sample, expv);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b exp 1", o_ready);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", o_valid);
    end
    checks++;
    if (o_sample !== 16'sd0) begin
      errors++; $display("FAIL reset_sample got %0d exp 0", o_sample);
    end
    i_rst_n = 1'b1;
    $display("txn reset ready=%0b valid=%0b sample=%0d", o_ready, o_valid, o_sample);
  endtask

  task automatic test_bypass();
    run_sample("bypass", 16'sd12345, 32'hC000_0000, 4'd8, 1'b0, 16'sd12345);
    run_sample("bypass_neg", -16'sd32768, 32'hC000_0000, 4'd8, 1'b0, -16'sd32768);
  endtask

  task automatic test_extremes();
    run_sample("lfo_min_d8", 16'sd12345, 32'hC000_0000, 4'd8, 1'b1, 16'sd0);
    run_sample("lfo_max_neg", -16'sd32768, 32'h4000_0000, 4'd8, 1'b1, -16'sd32768);
  endtask

  task automatic test_midscale();
    run_sample("mid_d8", -16'sd20000, 32'h0000_0000, 4'd8, 1'b1, -16'sd10000);
    run_sample("mid_d4", 16'sd20000, 32'h0000_0000, 4'd4, 1'b1, 16'sd15000);
    run_sample("mid_floor", -16'sd3, 32'h0000_0000, 4'd8, 1'b1, -16'sd2);
    // lfo=2^29 -> g=24576; depth 5 -> G=27648
    run_sample("q_d8", -16'sd1000, 32'h2000_0000, 4'd8, 1'b1, -16'sd750);
    run_sample("q_d5_pos", 16'sd1000, 32'h2000_0000, 4'd5, 1'b1, 16'sd843);
    run_sample("q_d5_neg", -16'sd1000, 32'h2000_0000, 4'd5, 1'b1, -16'sd844);
  endtask

  task automatic test_clamp();
    run_sample("clamp_hi", 16'sd1000, 32'h7FFF_FFFF, 4'd15, 1'b1, 16'sd1000);
    run_sample("clamp_lo", 16'sd1000, 32'h8000_0000, 4'd8, 1'b1, 16'sd0);
    run_sample("depth_clamp", 16'sd20000, 32'h0000_0000, 4'd15, 1'b1, 16'sd10000);
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] samples [3];
    logic signed [15:0] out_val [3];
    int out_cyc [3];
    int idx = 0;
    int nout = 0;
    samples[0] = 16'sd100; samples[1] = 16'sd200; samples[2] = 16'sd300;
    for (int i = 0; i < 3; i++) begin
      out_val[i] = '0; out_cyc[i] = 0;
    end
    for (int c = 0; c < 90 && nout < 3; c++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        out_cyc[nout] = c; out_val[nout] = o_sample; nout++;
      end
      if (o_ready === 1'b1 && idx < 3) begin
        i_valid = 1'b1; i_sample = samples[idx]; i_depth = 4'd0;
        i_lfo = 32'hC000_0000; i_en = 1'b1; idx++;
      end else begin
        i_valid = (idx < 3) || (o_ready !== 1'b1);
        i_sample = 16'sd7777; i_depth = 4'd8; i_lfo = 32'hC000_0000; i_en = 1'b1;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (nout != 3) begin
      errors++; $display("FAIL stream_count got %0d exp 3", nout);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_val[i] !== samples[i]) begin
        errors++; $display("FAIL stream_val%0d got %0d exp %0d", i, out_val[i], samples[i]);
      end
      $display("txn stream%0d out=%0d exp=%0d cycle=%0d", i, out_val[i], samples[i], out_cyc[i]);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] != 19) begin
        errors++;
        $display("FAIL stream_gap%0d got %0d exp 19", i, out_cyc[i] - out_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int pulses = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_sample = 16'sd5000; i_lfo = 32'h0; i_depth = 4'd0; i_en = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (7) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got %0b exp 1", o_ready);
    end
    checks++;
    if (o_sample !== 16'sd0) begin
      errors++; $display("FAIL midrst_sample got %0d exp 0", o_sample);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got %0b exp 0", o_valid);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midrst_pulses got %0d exp 0", pulses);
    end
    $display("txn midrst dropped pulses=%0d sample=%0d", pulses, o_sample);
    run_sample("after_reset", -16'sd20000, 32'h0000_0000, 4'd8, 1'b1, -16'sd10000);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_extremes();
    test_midscale();
    test_clamp();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
